// File: rtl/rr_mux8_sched_if.sv
// Requester/consumer-side bundle for the round-robin 8:1 mux scheduler.
// master drives requests, data and ready; slave is the scheduler itself.
interface rr_mux8_sched_if;
  logic [7:0] req;
  logic [7:0] din;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       y;
  logic       y_valid;
  logic       busy;

  modport master (
    output req, din, out_ready,
    input  sel, gnt, y, y_valid, busy
  );

  modport slave (
    input  req, din, out_ready,
    output sel, gnt, y, y_valid, busy
  );
endinterface

// File: rtl/rr_mux8_sched.sv
// Round-robin scheduler sharing one 8:1 single-bit mux among 8 requesters,
// capping each grant at HOLD_MAX accepted beats with a one-cycle idle bubble between grants.
module rr_mux8_sched #(
  parameter int HOLD_MAX = 4,
  parameter int CNTW     = 4
) (
  input logic             clk,
  input logic             rst_n,
  rr_mux8_sched_if.slave  bus
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t            state_q;
  logic [2:0]        sel_q;
  logic [2:0]        ptr_q;
  logic [7:0]        gnt_q;
  logic [CNTW-1:0]   cnt_q;

  logic [2:0]        win_d;
  logic [2:0]        cand;
  logic              winHit;
  logic              yValid;

  // Circular search starting just after the last winner; offset 8 wraps back onto ptr itself.
  always_comb begin
    win_d  = '0;
    winHit = 1'b0;
    cand   = '0;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!winHit && bus.req[cand]) begin
        win_d  = cand;
        winHit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= 3'd7;
    end else begin
      case (state_q)
        IDLE: begin
          if (winHit) begin
            sel_q   <= win_d;
            gnt_q   <= 8'b1 << win_d;
            ptr_q   <= win_d;
            cnt_q   <= '0;
            state_q <= SERVE;
          end
        end
        SERVE: begin
          // Withdrawal releases without counting; sel is kept so the mux stays stable in IDLE.
          if (!bus.req[sel_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
          end else if (bus.out_ready) begin
            if (cnt_q == CNTW'(HOLD_MAX - 1)) begin
              state_q <= IDLE;
              gnt_q   <= '0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign yValid      = (state_q == SERVE) && bus.req[sel_q];
  assign bus.y_valid = yValid;
  assign bus.y       = yValid & bus.din[sel_q];
  assign bus.sel     = sel_q;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q == SERVE);

endmodule

// File: tb/tb_rr_mux8_sched.sv
// Directed plus randomized bench for rr_mux8_sched, checked against a
// transaction-level model of the round-robin grant/beat rules.
module tb_rr_mux8_sched;

  localparam int HOLD = 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  rr_mux8_sched_if bus ();

  rr_mux8_sched #(.HOLD_MAX(HOLD), .CNTW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who holds the mux, how many beats it has moved, who won last.
  bit mServing;
  int mOwner;
  int mBeats;
  int mLast;
  bit lastXfer;

  function automatic int pickNext(input int last, input logic [7:0] r);
    for (int k = 1; k <= 8; k++)
      if (r[(last + k) % 8]) return (last + k) % 8;
    return -1;
  endfunction

  function automatic int onehotIndex(input logic [7:0] g);
    for (int i = 0; i < 8; i++)
      if (g[i]) return i;
    return -1;
  endfunction

  task automatic modelReset();
    mServing = 1'b0;
    mOwner   = 0;
    mBeats   = 0;
    mLast    = 7;
  endtask

  task automatic modelStep();
    int w;
    if (!mServing) begin
      w = pickNext(mLast, bus.req);
      if (w >= 0) begin
        mOwner   = w;
        mLast    = w;
        mBeats   = 0;
        mServing = 1'b1;
      end
    end else if (!bus.req[mOwner]) begin
      mServing = 1'b0;
    end else if (bus.out_ready) begin
      mBeats++;
      if (mBeats == HOLD) mServing = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [7:0] eG;
    logic       eV;
    logic       eY;
    eG = mServing ? (8'h01 << mOwner) : 8'h00;
    eV = mServing && bus.req[mOwner];
    eY = eV && bus.din[mOwner];
    check("gnt",     bus.gnt,              eG);
    check("sel",     {5'b0, bus.sel},      8'(mOwner));
    check("y_valid", {7'b0, bus.y_valid},  {7'b0, eV});
    check("y",       {7'b0, bus.y},        {7'b0, eY});
    check("busy",    {7'b0, bus.busy},     {7'b0, mServing});
  endtask

  // One clock: drive, settle, compare, then advance the model at the edge.
  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] d, input logic rdy);
    bus.req       = r;
    bus.din       = d;
    bus.out_ready = rdy;
    #1;
    checkOutput();
    lastXfer = bus.y_valid && bus.out_ready;
    @(posedge clk);
    if (!rst_n) modelReset();
    else        modelStep();
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int         xfers;
    int         grantLog[$];
    logic [7:0] prevG;
    logic [7:0] rr;
    bit         pat[6];

    vectors     = 0;
    miscompares = 0;
    lastXfer    = 1'b0;
    bus.req       = 8'h00;
    bus.din       = 8'h00;
    bus.out_ready = 1'b0;
    rst_n         = 1'b1;
    #2;

    // Single requester: 4 beats, bubble, re-grant to 0.
    applyReset();
    for (int i = 0; i < 12; i++) applyStimulus(8'h01, 8'($urandom), 1'b1);

    // All requesting: grant order 0..7,0.
    applyReset();
    prevG = 8'h00;
    for (int i = 0; i < 42; i++) begin
      applyStimulus(8'hFF, 8'($urandom), 1'b1);
      if (bus.gnt != 8'h00 && prevG == 8'h00) grantLog.push_back(onehotIndex(bus.gnt));
      prevG = bus.gnt;
    end
    check("t2Grants", 8'(grantLog.size()), 8'd9);
    for (int i = 0; i < grantLog.size(); i++) check("t2Order", 8'(grantLog[i]), 8'(i % 8));

    // Stalls freeze the count; next grant goes to 5.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    applyReset();
    applyStimulus(8'h04, 8'($urandom), 1'b1);
    xfers = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'h24, 8'($urandom), pat[i]);
      if (lastXfer) xfers++;
    end
    check("t3Xfers", 8'(xfers), 8'd4);
    applyStimulus(8'h24, 8'($urandom), 1'b0);
    check("t3Next", bus.gnt, 8'h20);

    // Withdrawal after 2 transfers, then circular search from 4 lands on 0.
    applyReset();
    applyStimulus(8'h08, 8'($urandom), 1'b1);
    applyStimulus(8'h08, 8'($urandom), 1'b1);
    applyStimulus(8'h08, 8'($urandom), 1'b1);
    applyStimulus(8'h01, 8'hFF, 1'b1);
    check("t4Withdraw", {7'b0, lastXfer}, 8'h00);
    applyStimulus(8'h09, 8'($urandom), 1'b1);
    check("t4Next", bus.gnt, 8'h01);

    // Async reset mid-grant, then ptr restarts at 7.
    applyReset();
    applyStimulus(8'h40, 8'($urandom), 1'b1);
    applyStimulus(8'h40, 8'hFF, 1'b1);
    applyStimulus(8'h40, 8'hFF, 1'b1);
    bus.din = 8'hFF;
    rst_n = 1'b0;
    #1;
    check("t5Gnt",    bus.gnt,             8'h00);
    check("t5Sel",    {5'b0, bus.sel},     8'h00);
    check("t5Valid",  {7'b0, bus.y_valid}, 8'h00);
    check("t5Y",      {7'b0, bus.y},       8'h00);
    check("t5Busy",   {7'b0, bus.busy},    8'h00);
    modelReset();
    applyStimulus(8'hC0, 8'($urandom), 1'b1);
    rst_n = 1'b1;
    applyStimulus(8'hC0, 8'($urandom), 1'b1);
    check("t5Regrant", bus.gnt, 8'h40);
    check("t5Sel6",    {5'b0, bus.sel}, 8'h06);

    // Idle hold, then a one-cycle pulse granted and immediately withdrawn.
    for (int i = 0; i < 10; i++) applyStimulus(8'h00, 8'($urandom), 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(8'h00, 8'($urandom), 1'b1);
    applyReset();
    for (int i = 0; i < 10; i++) applyStimulus(8'h00, 8'($urandom), 1'b1);
    applyStimulus(8'h10, 8'($urandom), 1'b1);
    check("t6Gnt4", bus.gnt, 8'h10);
    applyStimulus(8'h00, 8'hFF, 1'b1);
    check("t6NoXfer", {7'b0, lastXfer}, 8'h00);
    applyStimulus(8'h00, 8'($urandom), 1'b1);

    // Randomized traffic with sticky requests and a rare async reset.
    rr = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rr[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 150) == 0) begin
        rst_n = 1'b0;
        #1;
        modelReset();
        applyStimulus(rr, 8'($urandom), 1'b1);
        rst_n = 1'b1;
      end
      applyStimulus(rr, 8'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
